// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX input word, EX/MEM output word and stall lines.
// slave = execute stage, master = surrounding pipeline.
interface ex_stage_if;
  logic [57:0] pipeline_reg_in;
  logic [3:0]  opc_in;
  logic        memory_stall;
  logic [37:0] pipeline_reg_out;
  logic [3:0]  opc_out;
  logic        ex_stall;
  logic [2:0]  ex_op_dest;
  logic [15:0] ex_res;

  modport slave (
    input  pipeline_reg_in,
    input  opc_in,
    input  memory_stall,
    output pipeline_reg_out,
    output opc_out,
    output ex_stall,
    output ex_op_dest,
    output ex_res
  );

  modport master (
    output pipeline_reg_in,
    output opc_in,
    output memory_stall,
    input  pipeline_reg_out,
    input  opc_out,
    input  ex_stall,
    input  ex_op_dest,
    input  ex_res
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: 16-bit MIPS execute stage, ALU plus EX/MEM register.
// EX_MUL_EN compiles in the iterative shift-add multiplier (alu_op 1010).
module ex_stage (
  input  logic   clk,
  input  logic   rst,
  ex_stage_if.slave ex
);

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] st_data;
  logic [3:0]  alu_op;
  logic [21:0] ctrl;
  logic [15:0] alu_res;

  assign op_a    = ex.pipeline_reg_in[57:42];
  assign op_b    = ex.pipeline_reg_in[41:26];
  assign st_data = ex.pipeline_reg_in[25:10];
  assign alu_op  = ex.pipeline_reg_in[9:6];

  // {mem_we, store data, wb_en, wb_dest, wb_result_mux}
  assign ctrl = {ex.pipeline_reg_in[5], st_data,
                 ex.pipeline_reg_in[4:0]};

  assign ex.ex_op_dest = ex.pipeline_reg_in[3:1];
  assign ex.ex_res     = alu_res;

  // Single-cycle ALU; unlisted codes (and MUL) pass A
  always_comb begin
    alu_res = op_a;
    case (alu_op)
      4'h0: alu_res = op_a + op_b;
      4'h1: alu_res = op_a - op_b;
      4'h2: alu_res = op_a & op_b;
      4'h3: alu_res = op_a | op_b;
      4'h4: alu_res = op_a ^ op_b;
      4'h5: alu_res = ~(op_a | op_b);
      4'h6: alu_res = op_a << op_b[3:0];
      4'h7: alu_res = op_a >> op_b[3:0];
      4'h8: alu_res = 16'($signed(op_a) >>> op_b[3:0]);
      4'h9: alu_res = {15'b0,
                       $signed(op_a) < $signed(op_b)};
      default: alu_res = op_a;
    endcase
  end

  logic [37:0] out_q, out_d;
  logic [3:0]  opc_q, opc_d;

  assign ex.pipeline_reg_out = out_q;
  assign ex.opc_out          = opc_q;

`ifdef EX_MUL_EN

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] prod_q, prod_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_mul;

  assign is_mul = (alu_op == 4'hA);

  assign ex.ex_stall = (state_q == S_IDLE && is_mul) ||
                       (state_q == S_RUN);

  // Next-state for FSM, multiplier datapath and EX/MEM word
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    opc_d    = opc_q;
    if (!ex.memory_stall) begin
      unique case (1'b1)
        (state_q == S_RUN): begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 4'd1;
          out_d    = '0;
          opc_d    = '0;
          if (cnt_q == 4'd15) state_d = S_DONE;
        end
        (state_q == S_DONE): begin
          out_d   = {prod_q, ctrl};
          opc_d   = ex.opc_in;
          state_d = S_IDLE;
        end
        default: begin
          if (is_mul) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            prod_d   = '0;
            cnt_d    = '0;
            out_d    = '0;
            opc_d    = '0;
            state_d  = S_RUN;
          end else begin
            out_d = {alu_res, ctrl};
            opc_d = ex.opc_in;
          end
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      opc_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      opc_q    <= opc_d;
    end
  end

`else

  assign ex.ex_stall = 1'b0;

  // Register ALU result unless MEM is stalled
  always_comb begin
    out_d = out_q;
    opc_d = opc_q;
    if (!ex.memory_stall) begin
      out_d = {alu_res, ctrl};
      opc_d = ex.opc_in;
    end
  end

  // EX/MEM registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      opc_q <= '0;
    end else begin
      out_q <= out_d;
      opc_q <= opc_d;
    end
  end

`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage.
// Covers ALU ops, stalls, reset and (with EX_MUL_EN) the multiplier.
module tb_ex_stage;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ex_stage_if exi ();

  ex_stage dut (
    .clk (clk),
    .rst (rst_n),
    .ex  (exi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [57:0] mk(
    input logic [15:0] a, input logic [15:0] b,
    input logic [15:0] sd, input logic [3:0] op,
    input logic we, input logic wb,
    input logic [2:0] dest, input logic mux);
    return {a, b, sd, op, we, wb, dest, mux};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [51:0] vec [13];

`ifdef EX_MUL_EN
  task automatic run_mul(input string tag,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input logic [15:0] exp,
                         input int ms_start,
                         input int ms_len,
                         input int exp_stall);
    int cyc;
    int nstall;
    int bad;
    bit done;
    bit was;
    logic [37:0] prev;
    cyc = 0; nstall = 0; bad = 0; done = 0;
    exi.pipeline_reg_in = mk(a, b, 16'h0, 4'hA,
                             1'b0, 1'b1, 3'd5, 1'b1);
    exi.opc_in = 4'h9;
    while (!done && cyc < 60) begin
      exi.memory_stall = (cyc >= ms_start) &&
                         (cyc < ms_start + ms_len);
      was = exi.ex_stall;
      if (was) nstall++;
      prev = exi.pipeline_reg_out;
      step();
      if (exi.memory_stall && exi.pipeline_reg_out !== prev)
        bad++;
      if (was && (exi.pipeline_reg_out !== '0 ||
                  exi.opc_out !== 4'h0))
        bad++;
      if (!was) done = 1;
      cyc++;
    end
    exi.memory_stall = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_stall"}, 64'(nstall), 64'(exp_stall));
    chk({tag, "_bubble"}, 64'(bad), 64'd0);
    chk({tag, "_res"}, 64'(exi.pipeline_reg_out[37:22]),
        64'(exp));
    chk({tag, "_ctl"}, 64'(exi.pipeline_reg_out[4:0]),
        64'h1B);
    chk({tag, "_opc"}, 64'(exi.opc_out), 64'h9);
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    exi.pipeline_reg_in = '0;
    exi.opc_in = 4'h0;
    exi.memory_stall = 1'b0;

    // {op, A, B, expected}
    vec[0]  = {4'h0, 16'h7FFF, 16'h0001, 16'h8000};
    vec[1]  = {4'h1, 16'h0005, 16'h0007, 16'hFFFE};
    vec[2]  = {4'h2, 16'hF0F0, 16'h3CC3, 16'h30C0};
    vec[3]  = {4'h3, 16'hF0F0, 16'h3CC3, 16'hFCF3};
    vec[4]  = {4'h4, 16'hF0F0, 16'h3CC3, 16'hCC33};
    vec[5]  = {4'h5, 16'hF0F0, 16'h3CC3, 16'h030C};
    vec[6]  = {4'h6, 16'h0001, 16'h000F, 16'h8000};
    vec[7]  = {4'h7, 16'h8000, 16'h0004, 16'h0800};
    vec[8]  = {4'h8, 16'h8000, 16'h0004, 16'hF800};
    vec[9]  = {4'h8, 16'h9000, 16'h0014, 16'hF900};
    vec[10] = {4'h9, 16'hFFFF, 16'h0001, 16'h0001};
    vec[11] = {4'h9, 16'h0001, 16'hFFFF, 16'h0000};
    vec[12] = {4'hF, 16'hABCD, 16'h1234, 16'hABCD};

    step();
    step();
    chk("rst_out", 64'(exi.pipeline_reg_out), 64'h0);
    chk("rst_opc", 64'(exi.opc_out), 64'h0);
    chk("rst_stall", 64'(exi.ex_stall), 64'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      exi.pipeline_reg_in = mk(vec[i][47:32], vec[i][31:16],
                               16'h1234, vec[i][51:48],
                               1'b0, 1'b1, 3'd3, 1'b0);
      exi.opc_in = 4'(i + 1);
      #1;
      chk($sformatf("res%0d", i), 64'(exi.ex_res),
          64'(vec[i][15:0]));
      chk($sformatf("stl%0d", i), 64'(exi.ex_stall), 64'h0);
      step();
      chk($sformatf("out%0d", i),
          64'(exi.pipeline_reg_out[37:22]),
          64'(vec[i][15:0]));
      chk($sformatf("opc%0d", i), 64'(exi.opc_out),
          64'(i + 1));
    end
    chk("add_ctl", 64'(exi.pipeline_reg_out[4:1]), 64'hB);
    chk("dest", 64'(exi.ex_op_dest), 64'h3);

    // store path fields
    exi.pipeline_reg_in = mk(16'h0010, 16'h0004, 16'hBEEF,
                             4'h0, 1'b1, 1'b0, 3'd6, 1'b1);
    step();
    chk("st_word", 64'(exi.pipeline_reg_out),
        64'({16'h0014, 1'b1, 16'hBEEF, 1'b0, 3'd6, 1'b1}));

    // memory_stall freezes a non-MUL result
    exi.memory_stall = 1'b1;
    exi.pipeline_reg_in = mk(16'h0001, 16'h0001, 16'h0,
                             4'h0, 1'b0, 1'b1, 3'd1, 1'b0);
    exi.opc_in = 4'h7;
    step();
    step();
    chk("ms_hold", 64'(exi.pipeline_reg_out[37:22]),
        64'h0014);
    chk("ms_opc", 64'(exi.opc_out), 64'hD);
    exi.memory_stall = 1'b0;
    step();
    chk("ms_rel", 64'(exi.pipeline_reg_out[37:22]),
        64'h0002);

`ifdef EX_MUL_EN
    run_mul("mul1", 16'h0123, 16'h0045, 16'h4E6F, 99, 0, 17);
    run_mul("mul2", 16'hFFFF, 16'h0002, 16'hFFFE, 5, 3, 20);

    // reset at RUN iteration 8
    exi.pipeline_reg_in = mk(16'h0123, 16'h0045, 16'h0,
                             4'hA, 1'b0, 1'b1, 3'd5, 1'b1);
    step();
    for (int i = 0; i < 8; i++) step();
    chk("mr_stall", 64'(exi.ex_stall), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_out", 64'(exi.pipeline_reg_out), 64'h0);
    chk("mr_opc", 64'(exi.opc_out), 64'h0);
    chk("mr_idle", 64'(exi.ex_stall), 64'h1);
`else
    exi.pipeline_reg_in = mk(16'h0123, 16'h0045, 16'h0,
                             4'hA, 1'b0, 1'b1, 3'd5, 1'b1);
    exi.opc_in = 4'h9;
    #1;
    chk("mul_stall", 64'(exi.ex_stall), 64'h0);
    step();
    chk("mul_passa", 64'(exi.pipeline_reg_out[37:22]),
        64'h0123);
    chk("mul_opc", 64'(exi.opc_out), 64'h9);
    rst_n = 1'b0;
    #1;
    chk("mr_out", 64'(exi.pipeline_reg_out), 64'h0);
    chk("mr_opc", 64'(exi.opc_out), 64'h0);
`endif

    exi.pipeline_reg_in = mk(16'h0001, 16'h0002, 16'h0,
                             4'h0, 1'b0, 1'b1, 3'd2, 1'b0);
    exi.opc_in = 4'h3;
    #1;
    chk("ar_stall", 64'(exi.ex_stall), 64'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_res", 64'(exi.pipeline_reg_out[37:22]), 64'h3);
    chk("ar_opc", 64'(exi.opc_out), 64'h3);
    for (int i = 0; i < 20; i++) begin
      step();
      if (exi.pipeline_reg_out[37:22] !== 16'h3 ||
          exi.ex_stall !== 1'b0)
        chk($sformatf("ar_hold%0d", i),
            64'(exi.pipeline_reg_out[37:22]), 64'h3);
    end
    chk("ar_final", 64'(exi.pipeline_reg_out[37:22]), 64'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
